// File: rtl/eth_pkg.sv
// Shared types, constants and the byte-wide reflected CRC32 step used by the
// Ethernet TX framer and the RX checker.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN  = 7;

  // One byte of the LSB-first CRC32; the caller inverts the result for the FCS.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-serial CRC32 accumulator; init has priority over en.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_next(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, payload, zero pad, FCS and
// inter-frame gap towards rmii_send.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for in_valid; no byte consumed
// PRE      | emitting 7 preamble bytes
// SFD      | emitting the start-of-frame delimiter
// DATA     | forwarding accepted payload bytes (latency 1)
// PAD      | emitting zero bytes up to MIN_LEN
// FCS      | emitting ~CRC, LSB byte first
// DRAIN    | discarding input after an abort until in_last
// IFG      | idle gap before the next frame
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  phy_tx_data,
  output logic        phy_tx_valid,
  output logic        tx_busy,
  output logic        err_underrun,
  output logic        err_oversize,
  output logic [15:0] frames_ok
);

  localparam int               CNT_W     = 11;
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  // The IDLE cycle before PRE is itself one idle byte time, so IFG is one short.
  localparam logic [7:0]       IFG_LOAD  = (IFG_BYTES > 1) ? 8'(IFG_BYTES - 1) : 8'd1;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       ifg_q, ifg_d;
  logic [7:0]       phy_data_q, phy_data_d;
  logic             phy_valid_q, phy_valid_d;
  logic             busy_q, busy_d;
  logic             err_u_q, err_u_d;
  logic             err_o_q, err_o_d;
  logic [15:0]      ok_q, ok_d;

  logic             crc_init, crc_en;
  logic [7:0]       crc_din;
  logic [31:0]      crc, fcs;

  eth_crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (crc_din),
    .crc   (crc)
  );

  assign in_ready = (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign cnt_inc  = cnt_q + 1'b1;
  assign fcs      = ~crc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ifg_d       = ifg_q;
    phy_data_d  = 8'h00;
    phy_valid_d = 1'b0;
    err_u_d     = 1'b0;
    err_o_d     = 1'b0;
    ok_d        = ok_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_din     = in_data;

    case (state_q)
      ST_IDLE: begin
        crc_init = 1'b1;
        cnt_d    = '0;
        if (in_valid) state_d = ST_PRE;
      end
      ST_PRE: begin
        phy_data_d  = PREAMBLE_BYTE;
        phy_valid_d = 1'b1;
        cnt_d       = cnt_inc;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end
      end
      ST_SFD: begin
        phy_data_d  = SFD_BYTE;
        phy_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_DATA;
      end
      ST_DATA: begin
        if (in_valid) begin
          phy_data_d  = in_data;
          phy_valid_d = 1'b1;
          crc_en      = 1'b1;
          cnt_d       = cnt_inc;
          if (in_last) begin
            if (cnt_inc < MIN_LEN_C) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
              cnt_d   = '0;
            end
          end else if (cnt_inc == MAX_LEN_C) begin
            state_d = ST_DRAIN;
            err_o_d = 1'b1;
          end
        end else begin
          state_d = ST_DRAIN;
          err_u_d = 1'b1;
        end
      end
      ST_PAD: begin
        phy_valid_d = 1'b1;
        crc_en      = 1'b1;
        crc_din     = 8'h00;
        cnt_d       = cnt_inc;
        if (cnt_inc >= MIN_LEN_C) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end
      end
      ST_FCS: begin
        phy_data_d  = 8'(fcs >> {cnt_q[1:0], 3'b000});
        phy_valid_d = 1'b1;
        cnt_d       = cnt_inc;
        if (cnt_q[1:0] == 2'd3) begin
          state_d  = ST_IFG;
          cnt_d    = '0;
          ifg_d    = IFG_LOAD;
          ok_d     = ok_q + 16'd1;
          crc_init = 1'b1;
        end
      end
      ST_DRAIN: begin
        crc_init = 1'b1;
        if (in_valid && in_last) begin
          state_d = ST_IFG;
          ifg_d   = IFG_LOAD;
        end
      end
      ST_IFG: begin
        if (ifg_q <= 8'd1) begin
          state_d = ST_IDLE;
          ifg_d   = 8'd0;
        end else begin
          ifg_d = ifg_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ifg_q       <= 8'd0;
      phy_data_q  <= 8'h00;
      phy_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_u_q     <= 1'b0;
      err_o_q     <= 1'b0;
      ok_q        <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ifg_q       <= ifg_d;
      phy_data_q  <= phy_data_d;
      phy_valid_q <= phy_valid_d;
      busy_q      <= busy_d;
      err_u_q     <= err_u_d;
      err_o_q     <= err_o_d;
      ok_q        <= ok_d;
    end
  end

  assign phy_tx_data  = phy_data_q;
  assign phy_tx_valid = phy_valid_q;
  assign tx_busy      = busy_q;
  assign err_underrun = err_u_q;
  assign err_oversize = err_o_q;
  assign frames_ok    = ok_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: a default instance and a MIN_LEN=0
// instance, driven from a table of frame vectors plus a mid-frame reset.
module tb_eth_tx_framer;

  // fields: min0 ascii split len drop_at abort_at seed exp_bytes exp_under exp_over exp_good
  typedef struct {
    int min0;
    int ascii;
    int split;
    int len;
    int drop_at;
    int abort_at;
    int seed;
    int exp_bytes;
    int exp_under;
    int exp_over;
    int exp_good;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  logic        drv_valid = 1'b0;
  logic        drv_last = 1'b0;

  logic        rdy1, val1, busy1, eu1, eo1;
  logic [7:0]  data1;
  logic [15:0] ok1;
  logic        rdy0, val0, busy0, eu0, eo0;
  logic [7:0]  data0;
  logic [15:0] ok0;

  logic        obs_ready, obs_valid, obs_busy, obs_eu, obs_eo;
  logic [7:0]  obs_data;
  logic [15:0] obs_ok;

  always #5 clk = ~clk;

  eth_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (drv_data),
    .in_valid     (drv_valid & ~sel),
    .in_last      (drv_last),
    .in_ready     (rdy1),
    .phy_tx_data  (data1),
    .phy_tx_valid (val1),
    .tx_busy      (busy1),
    .err_underrun (eu1),
    .err_oversize (eo1),
    .frames_ok    (ok1)
  );

  eth_tx_framer #(.MIN_LEN(0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (drv_data),
    .in_valid     (drv_valid & sel),
    .in_last      (drv_last),
    .in_ready     (rdy0),
    .phy_tx_data  (data0),
    .phy_tx_valid (val0),
    .tx_busy      (busy0),
    .err_underrun (eu0),
    .err_oversize (eo0),
    .frames_ok    (ok0)
  );

  assign obs_ready = sel ? rdy0  : rdy1;
  assign obs_valid = sel ? val0  : val1;
  assign obs_busy  = sel ? busy0 : busy1;
  assign obs_eu    = sel ? eu0   : eu1;
  assign obs_eo    = sel ? eo0   : eo1;
  assign obs_data  = sel ? data0 : data1;
  assign obs_ok    = sel ? ok0   : ok1;

  int checks = 0;
  int errors = 0;
  int exp_ok0 = 0;
  int exp_ok1 = 0;

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int idx, cyc, bursts, gap, gap_run, nu, no, data_nz, done;
  logic prev_v;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic logic [7:0] pay(input vec_t v, input int i);
    if (v.ascii != 0) return 8'(8'h31 + i);
    return 8'(i * 13 + v.seed);
  endfunction

  task automatic build_exp(input vec_t v);
    int nfr, flen, minl, k;
    logic [31:0] c;
    exp_q.delete();
    nfr  = (v.split != 0) ? 2 : 1;
    flen = (v.split != 0) ? v.len / 2 : v.len;
    minl = (v.min0 != 0) ? 0 : 60;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      if (v.drop_at > 0 || v.len > 1514) begin
        k = (v.drop_at > 0) ? v.drop_at : 1514;
        for (int i = 0; i < k; i++) exp_q.push_back(pay(v, i));
      end else begin
        c = 32'hFFFFFFFF;
        for (int i = 0; i < flen; i++) begin
          exp_q.push_back(pay(v, f * flen + i));
          c = m_crc(c, pay(v, f * flen + i));
        end
        for (int i = flen; i < minl; i++) begin
          exp_q.push_back(8'h00);
          c = m_crc(c, 8'h00);
        end
        c = ~c;
        for (int b = 0; b < 4; b++) exp_q.push_back(c[8*b +: 8]);
      end
    end
  endtask

  task automatic drive(input vec_t v, inout int drops);
    if (idx < v.len && !(v.drop_at > 0 && idx == v.drop_at && drops < 2)) begin
      drv_valid = 1'b1;
      drv_data  = pay(v, idx);
      drv_last  = (idx == v.len - 1) || (v.split != 0 && idx == v.len / 2 - 1);
    end else begin
      if (v.drop_at > 0 && idx == v.drop_at) drops++;
      drv_valid = 1'b0;
      drv_data  = 8'h00;
      drv_last  = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic rdy_prev;
    int drops;
    sel = (v.min0 != 0);
    cap.delete();
    idx = 0; cyc = 0; bursts = 0; gap = -1; gap_run = 0;
    nu = 0; no = 0; data_nz = 0; done = 0; prev_v = 1'b0; drops = 0;
    drive(v, drops);
    rdy_prev = obs_ready;
    while (done == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (obs_valid) begin
        if (!prev_v) begin
          bursts++;
          if (bursts == 2) gap = gap_run;
        end
        cap.push_back(obs_data);
        gap_run = 0;
      end else begin
        if (obs_data != 8'h00) data_nz++;
        if (bursts > 0) gap_run++;
      end
      prev_v = obs_valid;
      if (obs_eu) nu++;
      if (obs_eo) no++;
      if (drv_valid && rdy_prev) idx++;
      rdy_prev = obs_ready;
      if (v.abort_at > 0 && cyc == v.abort_at) return;
      drive(v, drops);
      if (idx == v.len && !obs_busy && cyc > 2) done = 1;
    end
  endtask

  task automatic check_vec(input int n, input vec_t v);
    int mism;
    string t;
    t = $sformatf("v%0d", n);
    build_exp(v);
    chk({t, "_done"}, done, 1);
    chk({t, "_accepted"}, idx, v.len);
    chk({t, "_valid_bytes"}, cap.size(), v.exp_bytes);
    mism = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i] && mism < 0) mism = i;
    chk({t, "_stream_first_mismatch"}, mism, -1);
    chk({t, "_bursts"}, bursts, (v.split != 0) ? 2 : 1);
    chk({t, "_err_underrun"}, nu, v.exp_under);
    chk({t, "_err_oversize"}, no, v.exp_over);
    chk({t, "_idle_data_zero"}, data_nz, 0);
    if (v.min0 != 0) begin
      exp_ok0 += v.exp_good;
      chk({t, "_frames_ok"}, obs_ok, exp_ok0);
    end else begin
      exp_ok1 += v.exp_good;
      chk({t, "_frames_ok"}, obs_ok, exp_ok1);
    end
    if (v.split != 0) chk({t, "_ifg_gap"}, gap, 12);
    if (v.ascii != 0 && cap.size() == 21)
      chk({t, "_fcs_cbf43926"}, {cap[20], cap[19], cap[18], cap[17]}, 32'hCBF43926);
  endtask

  task automatic check_reset_state(input string t);
    chk({t, "_valid"}, obs_valid, 0);
    chk({t, "_data"}, obs_data, 0);
    chk({t, "_ready"}, obs_ready, 0);
    chk({t, "_busy"}, obs_busy, 0);
    chk({t, "_errs"}, {obs_eu, obs_eo}, 0);
    chk({t, "_frames_ok"}, obs_ok, 0);
  endtask

  initial begin
    vec_t va, vp;
    vecs[0] = '{1, 1, 0,    9,  0, 0,  0,   21, 0, 0, 1};
    vecs[1] = '{0, 0, 0,   14,  0, 0,  5,   72, 0, 0, 1};
    vecs[2] = '{0, 0, 0,    1,  0, 0, 77,   72, 0, 0, 1};
    vecs[3] = '{0, 0, 0,   61,  0, 0,  9,   73, 0, 0, 1};
    vecs[4] = '{0, 0, 1,  120,  0, 0, 33,  144, 0, 0, 2};
    vecs[5] = '{0, 0, 0,   40, 20, 0, 21,   28, 1, 0, 0};
    vecs[6] = '{0, 0, 0, 1600,  0, 0,  3, 1522, 0, 1, 0};
    vecs[7] = '{0, 0, 0, 1514,  0, 0, 11, 1526, 0, 0, 1};
    va      = '{0, 0, 0,   60,  0, 30, 1,    0, 0, 0, 0};
    vp      = '{0, 0, 0,   14,  0, 0, 99,   72, 0, 0, 1};

    #12;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 8; n++) begin
      run_vec(vecs[n]);
      check_vec(n, vecs[n]);
    end

    run_vec(va);
    chk("pre_reset_valid", obs_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_data  = 8'h00;
    exp_ok0 = 0;
    exp_ok1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vp);
    check_vec(8, vp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
Byte-wide Ethernet TX MAC framer. It sits directly upstream of rmii_send, in the phy_clk_div4 (12.5 MHz byte-rate) domain.
- Takes a payload byte stream (DA through end of payload) with a valid/ready/last handshake.
- Emits preamble and SFD, the payload, zero padding up to the minimum length, and the CRC32 FCS.
- Enforces the inter-frame gap, and drives phy_tx_data/phy_tx_valid one byte per clk.

Parameters:
- MIN_LEN, 60, minimum DA..pad byte count before FCS; 0 disables padding.
- MAX_LEN, 1514, maximum DA..payload byte count; beyond this the frame is truncated.
- IFG_BYTES, 12, idle byte times after FCS or after an abort.

Ports:
- clk  in  1  byte clock (phy_clk_div4).
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final payload byte.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- phy_tx_data  out  8  byte to rmii_send.
- phy_tx_valid  out  1  byte valid to rmii_send; contiguous for a whole frame.
- tx_busy  out  1  high in any state other than IDLE.
- err_underrun  out  1  one-clk pulse on underrun abort.
- err_oversize  out  1  one-clk pulse on oversize abort.
- frames_ok  out  16  count of frames completed with FCS; wraps at 0xFFFF->0.

Behaviour:
- Reset: async assert forces IDLE immediately, including mid-frame.
  - phy_tx_data=0x00, phy_tx_valid=0, in_ready=0, tx_busy=0, err_*=0, frames_ok=0.
  - CRC register = 0xFFFFFFFF; byte and IFG counters = 0.
  - Deassertion takes effect on the next rising clk.
- All outputs except in_ready are registered. in_ready is decoded from state: 1 in DATA and DRAIN only.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE: if in_valid=1 at edge N, go to PRE (no byte is consumed).
  - Edges N+1..N+7: phy_tx_data=0x55.
  - Edge N+8: phy_tx_data=0xD5 (SFD).
  - DATA is entered so that the first payload byte appears at edge N+9.
- DATA: each accepted byte is registered onto phy_tx_data at the next edge (latency 1), fed into the CRC, and increments the 11-bit byte count.
  - Accepted with in_last: if count < MIN_LEN go to PAD, else go to FCS.
  - in_valid=0 in DATA (underrun):
    - phy_tx_valid=0 at the next edge; err_underrun pulses for 1 clk.
    - Go to DRAIN. No FCS is sent; frames_ok is unchanged.
  - MAX_LEN-th byte accepted without in_last (oversize):
    - That byte is sent; phy_tx_valid=0 at the following edge; err_oversize pulses.
    - Go to DRAIN.
  - MAX_LEN-th byte accepted with in_last: normal completion.
- PAD: emit 0x00 and update the CRC until count == MIN_LEN, then go to FCS.
- FCS: emit ~CRC over DA..pad as 4 bytes, LSB byte first.
  - CRC is reflected, poly 0xEDB88320, init 0xFFFFFFFF, updated one byte per clk.
  - After the 4th byte: frames_ok += 1, CRC reinitialised, go to IFG.
- DRAIN: in_ready=1, bytes are discarded; phy_tx_valid=0. Leave on an accepted byte with in_last, then go to IFG.
- IFG: phy_tx_valid=0 for IFG_BYTES clks, then IDLE. in_valid is ignored during IFG.
- Simultaneous events:
  - in_last and the underrun check cannot coincide (underrun requires in_valid=0).
  - An oversize byte that carries in_last counts as a good frame.
- phy_tx_valid is never deasserted between SFD and the final FCS byte except on abort.
- phy_tx_data=0x00 whenever phy_tx_valid=0.

Decomposition:
- Package eth_pkg holds:
  - tx_state_t enum.
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF.
  - Function crc32_next(crc, byte).
- One sub-module, eth_crc32_d8 (clk, rst_n, init, en, data[7:0] -> crc[31:0]), reused later by the RX checker.
- The FSM, counters and output registers live in eth_tx_framer.

Test Plan:
- MIN_LEN=0; send ASCII "123456789" with in_last on '9'.
  - Expect 7x55, D5, 31..39, then FCS bytes 26 39 F4 CB, then 12 idle clks.
  - Expect frames_ok=1.
- Default params; send a 14-byte frame.
  - Expect 46 bytes of 0x00 padding, FCS over 60 bytes matching the reference model, and a 72-byte valid burst (8+60+4).
- Drop in_valid after the 20th byte.
  - Expect phy_tx_valid low the next clk, err_underrun pulse, input drained until in_last, no FCS, frames_ok unchanged.
- Send 1600 bytes with MAX_LEN=1514.
  - Expect 8+1514 bytes valid, err_oversize pulse, remaining 86 bytes drained, then IFG.
- Two back-to-back 60-byte frames with in_valid held high.
  - Expect the second preamble to start exactly 12 clks after the first frame's last FCS byte.
  - Expect frames_ok=2.
- Assert rst_n=0 mid-DATA.
  - Expect phy_tx_valid=0 asynchronously and all outputs at reset values.
  - After release, a new frame starts cleanly with a correct FCS.
